// File: rtl/add_scheduler.sv
// add_scheduler: round-robin arbiter sharing one multi-cycle add unit among N_REQ requesters.
// Revision 1.0 - initial release.
`default_nettype none

module add_scheduler #(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = 3,
  parameter int RESULT_DELAY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_num1,
  input  logic [N_REQ*WIDTH-1:0] req_num2,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic [WIDTH-1:0]       add_num1,
  output logic [WIDTH-1:0]       add_num2,
  output logic                   add_enable,
  input  logic                   add_done,
  input  logic [WIDTH-1:0]       add_sum,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  localparam int CW = $clog2(RESULT_DELAY + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(RESULT_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    RESPOND = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [2:0]      ptr;
  logic [CW-1:0]   settle_cnt;
  logic            found;
  logic [2:0]      winner;
  logic [WIDTH-1:0] sel_num1, sel_num2;
  logic            accept;

  // Round-robin search starting at ptr; first valid requester in rotated order wins.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (j == (int'(ptr) + i) % N_REQ) && req_valid[j]) begin
          found  = 1'b1;
          winner = 3'(j);
        end
      end
    end
  end

  always_comb begin
    sel_num1 = '0;
    sel_num2 = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (3'(j) == winner) begin
        sel_num1 = req_num1[j*WIDTH +: WIDTH];
        sel_num2 = req_num2[j*WIDTH +: WIDTH];
      end
    end
  end

  // A stale done from the previous job blocks new grants until add has cleared it.
  assign accept = (state == IDLE) && !add_done && found;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= 3'd0;
      grant_id   <= 3'd0;
      add_num1   <= '0;
      add_num2   <= '0;
      rsp_sum    <= '0;
      settle_cnt <= '0;
    end else begin
      if (accept) begin
        add_num1 <= sel_num1;
        add_num2 <= sel_num2;
        grant_id <= winner;
        ptr      <= (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
      end
      if (state == RUN && add_done) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (state == CAPTURE) begin
        rsp_sum <= add_sum;
      end
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = '0;
    rsp_valid  = '0;
    add_enable = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready = N_REQ'(1) << winner;
          state_n   = RUN;
        end
      end
      RUN: begin
        add_enable = 1'b1;
        if (add_done) begin
          state_n = (RESULT_DELAY == 1) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        // SETTLE occupies RESULT_DELAY-1 cycles; leave on the last one.
        if (settle_cnt <= CW'(1)) begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        state_n = RESPOND;
      end
      RESPOND: begin
        rsp_valid = N_REQ'(1) << grant_id;
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_add_scheduler.sv
// tb_add_scheduler: scoreboard bench for add_scheduler with a behavioural model of the add unit.
`default_nettype none

module tb_add_scheduler;

  localparam int N_REQ        = 4;
  localparam int WIDTH        = 3;
  localparam int RESULT_DELAY = 2;
  localparam int LATENCY      = 1029;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_num1;
  logic [N_REQ*WIDTH-1:0] req_num2;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_sum;
  logic [WIDTH-1:0]       add_num1;
  logic [WIDTH-1:0]       add_num2;
  logic                   add_enable;
  logic                   add_done;
  logic [WIDTH-1:0]       add_sum;
  logic                   busy;
  logic [2:0]             grant_id;

  logic [WIDTH-1:0] op_a [N_REQ];
  logic [WIDTH-1:0] op_b [N_REQ];
  logic             force_done;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_num1[i*WIDTH +: WIDTH] = op_a[i];
      req_num2[i*WIDTH +: WIDTH] = op_b[i];
    end
  end

  add_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .RESULT_DELAY(RESULT_DELAY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num1(req_num1), .req_num2(req_num2),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
    .add_num1(add_num1), .add_num2(add_num2), .add_enable(add_enable),
    .add_done(add_done), .add_sum(add_sum),
    .busy(busy), .grant_id(grant_id)
  );

  // Behavioural add: 1024-cycle count, done for 3 cycles, sum registered one cycle after done rises.
  logic [1:0]       m_st;
  logic [9:0]       m_cnt;
  logic [1:0]       m_dc;
  logic             m_done;
  logic [WIDTH-1:0] m_sum;

  always @(posedge clk) begin
    if (reset) begin
      m_st <= 2'd0; m_cnt <= '0; m_dc <= '0; m_done <= 1'b0; m_sum <= '0;
    end else begin
      case (m_st)
        2'd0: begin
          m_done <= 1'b0;
          if (add_enable) begin
            m_st  <= 2'd1;
            m_cnt <= '0;
            m_sum <= ~(add_num1 + add_num2);
          end
        end
        2'd1: begin
          if (m_cnt == 10'd1023) begin
            m_st <= 2'd2; m_done <= 1'b1; m_dc <= '0;
          end else begin
            m_cnt <= m_cnt + 10'd1;
          end
        end
        default: begin
          m_dc <= m_dc + 2'd1;
          if (m_dc == 2'd1) m_sum <= add_num1 + add_num2;
          if (m_dc == 2'd2) begin
            m_done <= 1'b0; m_st <= 2'd0;
          end
        end
      endcase
    end
  end

  assign add_done = m_done | force_done;
  assign add_sum  = m_sum;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] sum;
    int               t0;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = '0; force_done = 1'b0;
    step(2);
    reset = 1'b0;
    sb.delete();
  endtask

  // Waits for the grant, checks it, and pushes the expected result; returns one cycle after accept.
  task automatic accept_job(input int exp_id);
    int   n;
    exp_t e;
    logic [N_REQ-1:0] want;
    #1;
    n = 0;
    while (req_ready == '0 && n < 3000) begin
      step(); #1; n++;
    end
    want = N_REQ'(1) << exp_id;
    checks++;
    if (req_ready !== want) begin
      errors++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, want);
      return;
    end
    e.id  = exp_id;
    e.sum = op_a[exp_id] + op_b[exp_id];
    e.t0  = cyc;
    sb.push_back(e);
    step();
  endtask

  task automatic finish_job(input bit idle_after);
    int   n, viol;
    logic prev_done;
    exp_t e;
    logic [N_REQ-1:0] want;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty, expected 1 pending job");
      return;
    end
    e = sb.pop_front();
    n = 0; viol = 0; prev_done = 1'b0;
    while (rsp_valid == '0 && n < 1200) begin
      if (req_ready !== '0) viol++;
      if (add_enable && add_done && prev_done) viol++;
      prev_done = add_done;
      step(); n++;
    end
    want = N_REQ'(1) << e.id;
    checks++;
    if (rsp_valid !== want) begin
      errors++;
      $display("FAIL rsp_valid: got %b expected %b", rsp_valid, want);
    end
    checks++;
    if (cyc - e.t0 !== LATENCY) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d", cyc - e.t0, LATENCY);
    end
    checks++;
    if (rsp_sum !== e.sum) begin
      errors++;
      $display("FAIL rsp_sum id%0d: got %0d expected %0d", e.id, rsp_sum, e.sum);
    end
    checks++;
    if (grant_id !== 3'(e.id)) begin
      errors++;
      $display("FAIL grant_id: got %0d expected %0d", grant_id, e.id);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL busy_rules: got %0d violations expected 0", viol);
    end
    if (idle_after) begin
      step();
      checks++;
      if ({busy, rsp_valid} !== '0 || rsp_sum !== e.sum) begin
        errors++;
        $display("FAIL after_rsp: busy=%b rsp_valid=%b rsp_sum=%0d expected 0/0/%0d",
                 busy, rsp_valid, rsp_sum, e.sum);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; force_done = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    step(3);
    checks++;
    if ({req_ready, rsp_valid, rsp_sum, add_num1, add_num2, add_enable, busy, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b rsp=%b sum=%0d n1=%0d n2=%0d en=%b busy=%b gid=%0d expected all 0",
               req_ready, rsp_valid, rsp_sum, add_num1, add_num2, add_enable, busy, grant_id);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    op_a[0] = 3'd3; op_b[0] = 3'd2;
    req_valid = 4'b0001;
    accept_job(0);
    req_valid = '0;
    finish_job(1'b1);
  endtask

  task automatic test_overflow();
    op_a[2] = 3'd7; op_b[2] = 3'd6;
    req_valid = 4'b0100;
    accept_job(2);
    req_valid = '0;
    finish_job(1'b1);
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    op_a[0] = 3'd1; op_b[0] = 3'd1;
    op_a[1] = 3'd2; op_b[1] = 3'd3;
    op_a[2] = 3'd5; op_b[2] = 3'd4;
    op_a[3] = 3'd6; op_b[3] = 3'd7;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      accept_job(order[k]);
      if (k == 4) req_valid = '0;
      finish_job(k == 4);
    end
  endtask

  task automatic test_operand_stability();
    op_a[0] = 3'd5; op_b[0] = 3'd1;
    req_valid = 4'b0001;
    accept_job(0);
    op_a[0] = 3'd2;
    step(10);
    checks++;
    if (add_num1 !== 3'd5 || add_num2 !== 3'd1) begin
      errors++;
      $display("FAIL operand_hold: got %0d/%0d expected 5/1", add_num1, add_num2);
    end
    req_valid = '0;
    finish_job(1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    apply_reset();
    op_a[0] = 3'd4; op_b[0] = 3'd3;
    req_valid = 4'b0001;
    accept_job(0);
    req_valid = '0;
    step(499);
    reset = 1'b1;
    step();
    checks++;
    if ({req_ready, rsp_valid, rsp_sum, add_num1, add_num2, add_enable, busy, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b rsp=%b sum=%0d n1=%0d n2=%0d en=%b busy=%b gid=%0d expected all 0",
               req_ready, rsp_valid, rsp_sum, add_num1, add_num2, add_enable, busy, grant_id);
    end
    reset = 1'b0;
    sb.delete();
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rsp_valid !== '0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL aborted_job: got %0d active cycles expected 0", seen);
    end
    op_a[1] = 3'd6; op_b[1] = 3'd1;
    req_valid = 4'b0010;
    accept_job(1);
    req_valid = '0;
    finish_job(1'b1);
  endtask

  task automatic test_stale_done();
    int bad;
    op_a[3] = 3'd4; op_b[3] = 3'd4;
    force_done = 1'b1;
    req_valid = 4'b1000;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (req_ready !== '0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stale_done: got %0d grant cycles expected 0", bad);
    end
    force_done = 1'b0;
    accept_job(3);
    req_valid = '0;
    finish_job(1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_operand_stability();
    test_reset_mid();
    test_stale_done();
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/add_scheduler.md
# add_scheduler

Round-robin scheduler that shares the single multi-cycle `add` unit among `N_REQ` independent requesters. It accepts one operand pair at a time through a valid/ready handshake and drives `add`'s `num1`/`num2`/`enable`. It waits on `add`'s `done`, captures `sum` at the point where `add` has registered it, and returns the result to the granted requester with a one-cycle response pulse. It sits between the LA/wishbone-facing control logic in `user_proj_example` and the `add` instance, replacing the ad-hoc top-level FSM.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 3: operand and result width; matches `add`.
- `RESULT_DELAY`, default 2: cycles from the first cycle `add_done`=1 is observed to the cycle `add_sum` is valid.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, same as `wb_clk_i`.
- `reset` in 1: synchronous, active-high; same net as `add.reset`.
- `req_valid` in N_REQ: per-requester request.
- `req_ready` out N_REQ: one-hot accept.
- `req_num1` in N_REQ*WIDTH: packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `req_num2` in N_REQ*WIDTH: packed operand B, same packing.
- `rsp_valid` out N_REQ: one-hot, one-cycle result pulse.
- `rsp_sum` out WIDTH: result; held until the next response.
- `add_num1` out WIDTH: to `add.num1`.
- `add_num2` out WIDTH: to `add.num2`.
- `add_enable` out 1: to `add.enable`.
- `add_done` in 1: from `add.done`.
- `add_sum` in WIDTH: from `add.sum`.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out 3: index of the current or last granted requester.

## Operation
States: IDLE, RUN, SETTLE, CAPTURE, RESPOND.

- **IDLE**
  - If any `req_valid` is set and `add_done`=0, pick a winner by round-robin: search from `ptr`, then ptr+1, … modulo N_REQ.
  - `req_ready[winner]`=1 combinationally in this cycle; the transfer completes on this edge.
  - At the edge: latch that requester's operands into `add_num1`/`add_num2`, set `grant_id`=winner, set `ptr`=(winner+1) mod N_REQ, go to RUN.
  - If `add_done`=1 (stale from a previous job), grant nothing and stay in IDLE.
- **RUN**
  - `add_enable`=1.
  - When `add_done`=1 is sampled: go to SETTLE with the settle counter loaded to RESULT_DELAY-1.
- **SETTLE**
  - `add_enable`=0.
  - Count down; at 0 go to CAPTURE.
  - If RESULT_DELAY=1, SETTLE is skipped.
- **CAPTURE**
  - `add_enable`=0.
  - Register `add_sum` into `rsp_sum`; go to RESPOND.
- **RESPOND**
  - `rsp_valid[grant_id]`=1 for exactly one cycle; next state IDLE.

Rules:
- `add_num1`/`add_num2` are held constant from acceptance until the next acceptance. They never change while `add` is BUSY or DONE.
- `req_ready` is 0 in every state except IDLE. At most one bit is set at any time.
- A requester must hold `req_valid` and its operands stable until it sees `req_ready`. Its request may stay asserted after acceptance. The next grant is arbitrated fresh.
- Arithmetic belongs to `add`: result is (A+B) mod 2^WIDTH, carry dropped. The scheduler does not modify `add_sum`.
- Reset at any time: state→IDLE, `ptr`=0. All outputs go to 0: `req_ready`, `rsp_valid`, `rsp_sum`, `add_num1`, `add_num2`, `add_enable`, `busy`, `grant_id`. No response is issued for an aborted job. `add` is reset by the same net.

## Timing
- Cycle 0 (IDLE, `req_ready` high) is the accept cycle. `add_enable` is high from cycle 1.
- With the current 10-bit-count `add`:
  - `add_done` is first seen in cycle 1026 (C).
  - SETTLE runs in cycle C+1 and CAPTURE in cycle C+2.
  - `rsp_valid` is high in cycle 1029.
- `add_enable` must be low by cycle C+1. This guarantees `add` returns to IDLE in cycle C+2 without restarting.
- `add_done` clears at the end of C+2. The earliest next accept is the cycle after RESPOND, giving back-to-back throughput of one job per 1030 cycles.
- `rsp_sum` changes only at the CAPTURE edge.

## Test plan
- **Single request:** reset, then req_valid[0]=1 with A=3, B=2 → `req_ready[0]` in cycle 0, `rsp_valid[0]` in cycle 1029, `rsp_sum`=5, `busy` low afterwards.
- **Overflow wrap:** requester 2, A=7, B=6 → `rsp_sum`=5, `rsp_valid[2]` only.
- **Round-robin:** all four requesters valid continuously with distinct operands → grants in order 0,1,2,3,0. Each `rsp_sum` is correct for its owner, and no requester is granted twice before the others are served.
- **Operand stability:** change req_num1[0] after acceptance → `add_num1` unchanged and the result uses the latched value. `req_ready` stays 0 outside IDLE.
- **Reset mid-job:** assert `reset` in cycle 500 of a job → all outputs 0 at the next cycle, no `rsp_valid`. A subsequent request to requester 1 is granted (ptr=0, requester 0 idle) and completes normally.
- **Stale done guard:** force `add_done`=1 while in IDLE with req_valid[3]=1 → no `req_ready` until `add_done`=0, then grant to 3.
